imp_sched: RTL and testbench
============================

# imp_sched

Timed impulse sequencer that consumes one command from the command-memory writer at a time (DATA_WR strobe plus command fields). It waits until system time reaches TIME_START and then emits N_impulse pulse slots, each with blanking windows. On completion, abort or rejection it raises REQ_COMM so the writer retires the command and supplies the next nearest one. It sits between the command-memory writer and the transmitter gating logic, on the 48 MHz system clock.

## Interface
- REQ_LEN, 4: REQ_COMM high time in clocks. Must be ≥3 because the writer edge-detects it.
- CLK in 1: system clock, 48 MHz.
- rst_n in 1: asynchronous, active-low reset.
- TIME in 64: system time in clocks, +1 per CLK except on a reload.
- SYS_TIME_UPDATE in 1: system time was reloaded. Level, held for several clocks.
- DATA_WR in 1: single-cycle command load strobe.
- TIME_START in 64: time of the first slot start.
- N_impulse in 16: number of pulse slots.
- TYPE_impulse in 2: impulse type, latched and passed through.
- Interval_Ti in 32: pulse width in clocks.
- Interval_Tp in 32: slot period in clocks.
- Tblank1 in 32: blanking before the pulse, in clocks.
- Tblank2 in 32: blanking after the pulse, in clocks.
- IMP out 1: impulse gate.
- BLANK out 1: receiver blanking; high during Tblank1, Ti and Tblank2.
- TYPE_z out 2: latched TYPE_impulse of the active command.
- IMP_CNT out 16: completed pulses of the current command.
- BUSY out 1: state ≠ IDLE.
- REQ_COMM out 1: next-command request.
- CMD_ERR out 1: one-clock pulse when a command is rejected or aborted.
- CMD_OVR out 1: one-clock pulse when a DATA_WR is ignored.

## Operation
- Reset values: all outputs 0, state IDLE, all counters 0, command registers 0.
- States: IDLE, ARMED, BLK1, PULSE, BLK2, GAP, DONE.

**Load (DATA_WR in IDLE or ARMED)**
- All fields are captured.
- Same-cycle validation on the input values. The command is rejected if any of these holds:
  - N_impulse = 0
  - Interval_Ti = 0
  - Tblank1 + Interval_Ti + Tblank2 > Interval_Tp, evaluated as a 34-bit sum with no truncation
  - TIME_START ≤ TIME
- On reject: CMD_ERR = 1 next clock, state goes to DONE.
- Otherwise: state goes to ARMED and IMP_CNT = 0.
- A load in ARMED replaces the armed command. This is legal, because the writer only re-sends when a nearer command appears.

**DATA_WR in any other state**
- Ignored; CMD_OVR pulses.

**ARMED**
- When TIME ≥ start_reg (unsigned 64-bit compare): enter BLK1, or PULSE if Tblank1 = 0. The period counter is reset to 0.

**Slot sequencing**
- A 32-bit period counter counts up from the first clock of the slot.
- BLK1 lasts Tblank1 clocks.
- PULSE lasts Ti clocks.
- BLK2 lasts Tblank2 clocks; it is skipped if 0.
- GAP runs until the period counter reaches Tp−1.
- At slot end: IMP_CNT increments.
  - If IMP_CNT+1 = N: go to DONE.
  - Else: start a new slot (BLK1 or PULSE) on the next clock, with no dead cycle.
- If Tb1+Ti+Tb2 = Tp, GAP takes zero clocks.

**Outputs per state**
- IMP = 1 only in PULSE.
- BLANK = 1 in BLK1, PULSE and BLK2.
- Both outputs are registered and decoded from the next state, so they align with the state.

**DONE**
- REQ_COMM = 1 for REQ_LEN clocks, then IDLE.

**SYS_TIME_UPDATE (rising edge detected internally)**
- In ARMED: re-evaluate. If start_reg ≤ TIME, go to DONE with CMD_ERR; otherwise keep waiting.
- In BLK1, PULSE, BLK2 or GAP: abort. IMP and BLANK go to 0 on the next clock, CMD_ERR pulses, state goes to DONE. IMP_CNT holds its value.
- In IDLE or DONE: no effect.

**Reset asserted mid-sequence**
- Outputs drop asynchronously to 0. No REQ_COMM is issued.

## Timing
- Load-to-ARMED: 1 clock.
- Let c be the first clock with TIME ≥ start_reg seen in ARMED:
  - BLANK rises at c+1.
  - IMP rises at c+1+Tblank1.
  - IMP is high for exactly Ti clocks.
- Slot k (0-based) starts at c+1+k·Tp.
- DONE is entered on the clock after the last GAP clock of slot N−1. REQ_COMM occupies that clock and the next REQ_LEN−1 clocks.
- Reject path: DATA_WR at t gives CMD_ERR at t+1 and REQ_COMM from t+1 through t+REQ_LEN.
- Simultaneous SYS_TIME_UPDATE edge and slot-end: the abort wins, with CMD_ERR.
- Simultaneous DATA_WR and TIME ≥ start in ARMED: the load wins and the new start is compared from the next clock.

## Test plan
- Nominal command: TIME=1000, TIME_START=1010, N=3, Ti=5, Tp=20, Tb1=2, Tb2=3.
  - IMP high at 1013–1017, 1033–1037 and 1053–1057.
  - BLANK high at 1011–1020, 1031–1040 and 1051–1060.
  - REQ_COMM high 1071–1074; IMP_CNT=3.
- Rejects, each giving CMD_ERR at t+1 and REQ_COMM for 4 clocks with IMP never high:
  - N=0
  - Ti=0
  - Tb1+Ti+Tb2 = Tp+1, i.e. 2+5+14 with Tp=20
  - TIME_START=TIME
- Zero blanking: Tb1=Tb2=0, Ti=Tp=4, N=2.
  - IMP high for 8 consecutive clocks.
  - BLANK equals IMP.
- Replace while armed: load start=5000 at T=100, then load start=300 at T=110.
  - The first pulse slot starts at 301.
  - The start=5000 command never fires.
  - A DATA_WR during PULSE produces CMD_OVR only.
- Time reload mid-sequence: assert SYS_TIME_UPDATE during the second PULSE.
  - IMP=0 the next clock, CMD_ERR=1, IMP_CNT=1, then REQ_COMM.
- Reset mid-sequence: drop rst_n during PULSE.
  - IMP, BLANK, BUSY and REQ_COMM are 0 immediately.
  - After release: state IDLE and IMP_CNT=0.

Source files
------------

// File: rtl/imp_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imp_sched: timed impulse sequencer, one command at a time, slot/blank gen  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module imp_sched #(
    parameter int unsigned REQ_LEN = 4
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic [63:0] TIME,
    input  logic        SYS_TIME_UPDATE,
    input  logic        DATA_WR,
    input  logic [63:0] TIME_START,
    input  logic [15:0] N_impulse,
    input  logic [1:0]  TYPE_impulse,
    input  logic [31:0] Interval_Ti,
    input  logic [31:0] Interval_Tp,
    input  logic [31:0] Tblank1,
    input  logic [31:0] Tblank2,
    output logic        IMP,
    output logic        BLANK,
    output logic [1:0]  TYPE_z,
    output logic [15:0] IMP_CNT,
    output logic        BUSY,
    output logic        REQ_COMM,
    output logic        CMD_ERR,
    output logic        CMD_OVR
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_BLK1  = 3'd2,
        S_PULSE = 3'd3,
        S_BLK2  = 3'd4,
        S_GAP   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [3:0] c_REQ_LAST = 4'(REQ_LEN - 1);

    state_t      r_state, w_nxt, w_first;
    logic        r_upd_d;
    logic [63:0] r_start;
    logic [15:0] r_n, r_imp_cnt;
    logic [1:0]  r_type;
    logic [31:0] r_ti, r_tp, r_tb1, r_tb2, r_pcnt;
    logic [3:0]  r_req_cnt;
    logic        r_imp, r_blank, r_busy, r_req, r_err, r_ovr;

    logic        w_upd_rise, w_valid, w_in_slot, w_slot_end;
    logic        w_load, w_err, w_ovr, w_slot_start, w_cnt_inc;
    logic [33:0] w_sum;
    logic [31:0] w_pn, w_end_pulse, w_end_blk2;

    assign w_upd_rise  = SYS_TIME_UPDATE & ~r_upd_d;
    // Widened sum so a huge blanking value cannot wrap past the period check
    assign w_sum       = {2'b00, Tblank1} + {2'b00, Interval_Ti} + {2'b00, Tblank2};
    assign w_valid     = (N_impulse != 16'd0) && (Interval_Ti != 32'd0) &&
                         (w_sum <= {2'b00, Interval_Tp}) && (TIME_START > TIME);
    assign w_first     = (r_tb1 != 32'd0) ? S_BLK1 : S_PULSE;
    assign w_pn        = r_pcnt + 32'd1;
    assign w_end_pulse = r_tb1 + r_ti;
    assign w_end_blk2  = w_end_pulse + r_tb2;
    assign w_slot_end  = (r_pcnt == r_tp - 32'd1);
    assign w_in_slot   = (r_state == S_BLK1) || (r_state == S_PULSE) ||
                         (r_state == S_BLK2) || (r_state == S_GAP);

    always_comb begin
        w_nxt        = r_state;
        w_load       = 1'b0;
        w_err        = 1'b0;
        w_ovr        = 1'b0;
        w_slot_start = 1'b0;
        w_cnt_inc    = 1'b0;
        case (r_state)
            S_IDLE, S_ARMED: begin
                if (DATA_WR) begin
                    w_load = 1'b1;
                    w_nxt  = w_valid ? S_ARMED : S_DONE;
                    w_err  = ~w_valid;
                end else if (r_state == S_ARMED) begin
                    if (w_upd_rise && (r_start <= TIME)) begin
                        w_nxt = S_DONE;
                        w_err = 1'b1;
                    end else if (TIME >= r_start) begin
                        w_nxt        = w_first;
                        w_slot_start = 1'b1;
                    end
                end
            end
            S_BLK1, S_PULSE, S_BLK2, S_GAP: begin
                w_ovr = DATA_WR;
                if (w_upd_rise) begin
                    w_nxt = S_DONE;
                    w_err = 1'b1;
                end else if (w_slot_end) begin
                    w_cnt_inc = 1'b1;
                    if (r_imp_cnt + 16'd1 == r_n) begin
                        w_nxt = S_DONE;
                    end else begin
                        w_nxt        = w_first;
                        w_slot_start = 1'b1;
                    end
                end else if (w_pn < r_tb1) begin
                    w_nxt = S_BLK1;
                end else if (w_pn < w_end_pulse) begin
                    w_nxt = S_PULSE;
                end else if (w_pn < w_end_blk2) begin
                    w_nxt = S_BLK2;
                end else begin
                    w_nxt = S_GAP;
                end
            end
            S_DONE: begin
                w_ovr = DATA_WR;
                if (r_req_cnt == c_REQ_LAST) begin
                    w_nxt = S_IDLE;
                end
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_upd_d   <= 1'b0;
            r_start   <= 64'd0;
            r_n       <= 16'd0;
            r_type    <= 2'd0;
            r_ti      <= 32'd0;
            r_tp      <= 32'd0;
            r_tb1     <= 32'd0;
            r_tb2     <= 32'd0;
            r_pcnt    <= 32'd0;
            r_imp_cnt <= 16'd0;
            r_req_cnt <= 4'd0;
            r_imp     <= 1'b0;
            r_blank   <= 1'b0;
            r_busy    <= 1'b0;
            r_req     <= 1'b0;
            r_err     <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_upd_d   <= SYS_TIME_UPDATE;
            r_req_cnt <= (r_state == S_DONE) ? r_req_cnt + 4'd1 : 4'd0;
            if (w_load) begin
                r_start <= TIME_START;
                r_n     <= N_impulse;
                r_type  <= TYPE_impulse;
                r_ti    <= Interval_Ti;
                r_tp    <= Interval_Tp;
                r_tb1   <= Tblank1;
                r_tb2   <= Tblank2;
            end
            if (w_slot_start) begin
                r_pcnt <= 32'd0;
            end else if (w_in_slot) begin
                r_pcnt <= w_pn;
            end
            if (w_load) begin
                r_imp_cnt <= 16'd0;
            end else if (w_cnt_inc) begin
                r_imp_cnt <= r_imp_cnt + 16'd1;
            end
            // Outputs decoded from the next state so they line up with it
            r_imp   <= (w_nxt == S_PULSE);
            r_blank <= (w_nxt == S_BLK1) || (w_nxt == S_PULSE) || (w_nxt == S_BLK2);
            r_busy  <= (w_nxt != S_IDLE);
            r_req   <= (w_nxt == S_DONE);
            r_err   <= w_err;
            r_ovr   <= w_ovr;
        end
    end

    assign IMP      = r_imp;
    assign BLANK    = r_blank;
    assign TYPE_z   = r_type;
    assign IMP_CNT  = r_imp_cnt;
    assign BUSY     = r_busy;
    assign REQ_COMM = r_req;
    assign CMD_ERR  = r_err;
    assign CMD_OVR  = r_ovr;
endmodule
`default_nettype wire

// File: tb/tb_imp_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_imp_sched: randomized self-checking bench with a time-domain slot model |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_imp_sched;
    localparam int unsigned REQ_LEN = 4;

    logic        CLK, rst_n, SYS_TIME_UPDATE, DATA_WR;
    logic [63:0] TIME, TIME_START;
    logic [15:0] N_impulse;
    logic [1:0]  TYPE_impulse;
    logic [31:0] Interval_Ti, Interval_Tp, Tblank1, Tblank2;
    logic        IMP, BLANK, BUSY, REQ_COMM, CMD_ERR, CMD_OVR;
    logic [1:0]  TYPE_z;
    logic [15:0] IMP_CNT;

    imp_sched #(.REQ_LEN(REQ_LEN)) dut (
        .CLK(CLK), .rst_n(rst_n), .TIME(TIME), .SYS_TIME_UPDATE(SYS_TIME_UPDATE),
        .DATA_WR(DATA_WR), .TIME_START(TIME_START), .N_impulse(N_impulse),
        .TYPE_impulse(TYPE_impulse), .Interval_Ti(Interval_Ti), .Interval_Tp(Interval_Tp),
        .Tblank1(Tblank1), .Tblank2(Tblank2), .IMP(IMP), .BLANK(BLANK), .TYPE_z(TYPE_z),
        .IMP_CNT(IMP_CNT), .BUSY(BUSY), .REQ_COMM(REQ_COMM), .CMD_ERR(CMD_ERR), .CMD_OVR(CMD_OVR)
    );

    always #5 CLK = ~CLK;

    int n_checks;
    int n_pass;

    int unsigned m_n, m_ti, m_tp, m_tb1, m_tb2;
    logic [1:0]  m_type;

    typedef struct packed {
        logic        imp;
        logic        blank;
        logic        req;
        logic        busy;
        logic [15:0] cnt;
    } exp_t;

    // Expected outputs at time t for the accepted command whose start time is c
    function automatic exp_t exp_at(input int unsigned t, input int unsigned c);
        exp_t e;
        int unsigned last, off, k;
        e = '0;
        last = c + m_n * m_tp;
        if (t <= c) begin
            e.busy = 1'b1;
        end else if (t <= last) begin
            k = (t - c - 1) / m_tp;
            off = (t - c - 1) % m_tp;
            e.busy  = 1'b1;
            e.cnt   = 16'(k);
            e.blank = (off < m_tb1 + m_ti + m_tb2);
            e.imp   = (off >= m_tb1) && (off < m_tb1 + m_ti);
        end else if (t <= last + REQ_LEN) begin
            e.busy = 1'b1;
            e.req  = 1'b1;
            e.cnt  = 16'(m_n);
        end else begin
            e.cnt = 16'(m_n);
        end
        return e;
    endfunction

    function automatic exp_t obs();
        return {IMP, BLANK, REQ_COMM, BUSY, IMP_CNT};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
        TIME = TIME + 64'd1;
    endtask

    task automatic load(input int unsigned start, input int unsigned n, input int unsigned ti,
                        input int unsigned tp, input int unsigned tb1, input int unsigned tb2);
        TIME_START   = 64'(start);
        N_impulse    = 16'(n);
        Interval_Ti  = ti;
        Interval_Tp  = tp;
        Tblank1      = tb1;
        Tblank2      = tb2;
        TYPE_impulse = 2'($urandom_range(0, 3));
        m_n = n; m_ti = ti; m_tp = tp; m_tb1 = tb1; m_tb2 = tb2; m_type = TYPE_impulse;
        DATA_WR = 1'b1;
        tick();
        DATA_WR = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++;
        if ({obs(), CMD_ERR, CMD_OVR, TYPE_z} !== '0)
            $display("FAIL reset_hold got %h want 0", {obs(), CMD_ERR, CMD_OVR, TYPE_z});
        else n_pass++;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({obs(), CMD_ERR, CMD_OVR, TYPE_z} !== '0)
            $display("FAIL reset_idle got %h want 0", {obs(), CMD_ERR, CMD_OVR, TYPE_z});
        else n_pass++;
    endtask

    task automatic test_nominal();
        exp_t e, o;
        int imp_cycles = 0;
        TIME = 64'd1000;
        load(1010, 3, 5, 20, 2, 3);
        while (TIME[31:0] <= 32'd1076) begin
            e = exp_at(TIME[31:0], 1010);
            o = obs();
            if (o.imp) imp_cycles++;
            n_checks++;
            if (o !== e)
                $display("FAIL nominal t=%0d got %b%b%b%b cnt=%0d want %b%b%b%b cnt=%0d", TIME,
                         o.imp, o.blank, o.req, o.busy, o.cnt, e.imp, e.blank, e.req, e.busy, e.cnt);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (imp_cycles != 15 || IMP_CNT !== 16'd3)
            $display("FAIL nominal_total imp_cycles=%0d cnt=%0d want 15 and 3", imp_cycles, IMP_CNT);
        else n_pass++;
    endtask

    task automatic test_reject();
        for (int k = 0; k < 5; k++) begin
            int unsigned n = 2, ti = 5, tp = 20, tb1 = 2, tb2 = 3;
            int unsigned start = TIME[31:0] + 10;
            logic seen_imp = 1'b0;
            case (k)
                0: n = 0;
                1: ti = 0;
                2: tb2 = 14;
                3: start = TIME[31:0];
                default: begin tb1 = 32'hFFFF_FFFF; ti = 1; tb2 = 0; tp = 32'hFFFF_FFFF; end
            endcase
            load(start, n, ti, tp, tb1, tb2);
            for (int j = 1; j <= 5; j++) begin
                if (j > 1) tick();
                if (IMP) seen_imp = 1'b1;
                n_checks++;
                if ({REQ_COMM, BUSY, CMD_ERR, BLANK} !== {j <= 4, j <= 4, j == 1, 1'b0})
                    $display("FAIL reject[%0d] t+%0d got req/busy/err/blank=%b%b%b%b want %b%b%b0",
                             k, j, REQ_COMM, BUSY, CMD_ERR, BLANK, j <= 4, j <= 4, j == 1);
                else n_pass++;
            end
            n_checks++;
            if (seen_imp) $display("FAIL reject_imp[%0d] got IMP=1 want 0", k);
            else n_pass++;
        end
    endtask

    task automatic test_zero_blank();
        exp_t e, o;
        int run = 0, best = 0;
        int unsigned c = TIME[31:0] + 5;
        load(c, 2, 4, 4, 0, 0);
        while (TIME[31:0] <= c + 8 + REQ_LEN + 1) begin
            e = exp_at(TIME[31:0], c);
            o = obs();
            run = o.imp ? run + 1 : 0;
            if (run > best) best = run;
            n_checks++;
            if (o !== e || BLANK !== IMP)
                $display("FAIL zero_blank t=%0d got imp/blank=%b%b want %b%b", TIME, o.imp, o.blank, e.imp, e.blank);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (best != 8) $display("FAIL zero_blank_run got %0d want 8", best);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            exp_t e, o;
            int unsigned n, tp, ti, tb1, tb2, c;
            n   = $urandom_range(1, 4);
            tp  = $urandom_range(2, 24);
            ti  = $urandom_range(1, tp);
            tb1 = $urandom_range(0, tp - ti);
            tb2 = $urandom_range(0, tp - ti - tb1);
            c   = TIME[31:0] + $urandom_range(1, 12);
            load(c, n, ti, tp, tb1, tb2);
            n_checks++;
            if (TYPE_z !== m_type) $display("FAIL random_type[%0d] got %0d want %0d", i, TYPE_z, m_type);
            else n_pass++;
            while (TIME[31:0] <= c + n * tp + REQ_LEN + 1) begin
                e = exp_at(TIME[31:0], c);
                o = obs();
                n_checks++;
                if ({o, CMD_ERR, CMD_OVR} !== {e, 2'b00})
                    $display("FAIL random[%0d] t=%0d got %b%b%b%b cnt=%0d err=%b want %b%b%b%b cnt=%0d", i, TIME,
                             o.imp, o.blank, o.req, o.busy, o.cnt, CMD_ERR, e.imp, e.blank, e.req, e.busy, e.cnt);
                else n_pass++;
                tick();
            end
        end
    endtask

    task automatic test_replace();
        exp_t e, o;
        logic inj = 1'b0, ovr_exp = 1'b0;
        int unsigned first_blank = 0;
        TIME = 64'd100;
        load(5000, 2, 5, 10, 1, 1);
        while (TIME[31:0] < 32'd110) tick();
        load(300, 2, 5, 10, 1, 1);
        while (TIME[31:0] <= 300 + 20 + REQ_LEN + 1) begin
            e = exp_at(TIME[31:0], 300);
            o = obs();
            if (o.blank && first_blank == 0) first_blank = TIME[31:0];
            n_checks++;
            if ({o, CMD_OVR, CMD_ERR} !== {e, ovr_exp, 1'b0})
                $display("FAIL replace t=%0d got %b%b%b%b ovr=%b err=%b want %b%b%b%b ovr=%b", TIME,
                         o.imp, o.blank, o.req, o.busy, CMD_OVR, CMD_ERR, e.imp, e.blank, e.req, e.busy, ovr_exp);
            else n_pass++;
            ovr_exp = 1'b0;
            if (e.imp && !inj) begin
                inj = 1'b1;
                ovr_exp = 1'b1;
                TIME_START = TIME + 64'd2;
                N_impulse = 16'd7;
                DATA_WR = 1'b1;
            end
            tick();
            DATA_WR = 1'b0;
        end
        n_checks++;
        if (first_blank != 301) $display("FAIL replace_start got %0d want 301", first_blank);
        else n_pass++;
        TIME = 64'd4998;
        for (int j = 0; j < 6; j++) begin
            tick();
            n_checks++;
            if ({BUSY, BLANK, IMP} !== 3'b000)
                $display("FAIL replace_old t=%0d got busy/blank/imp=%b%b%b want 000", TIME, BUSY, BLANK, IMP);
            else n_pass++;
        end
    endtask

    task automatic test_abort();
        exp_t e, o;
        logic found = 1'b0;
        int unsigned c = TIME[31:0] + 3;
        load(c, 3, 4, 10, 1, 1);
        for (int i = 0; i < 60 && !found; i++) begin
            e = exp_at(TIME[31:0], c);
            o = obs();
            n_checks++;
            if (o !== e) $display("FAIL abort_pre t=%0d got %h want %h", TIME, o, e);
            else n_pass++;
            if (e.imp && e.cnt == 16'd1) found = 1'b1;
            else tick();
        end
        n_checks++;
        if (!found) $display("FAIL abort_reach got no second pulse want one");
        else n_pass++;
        SYS_TIME_UPDATE = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            tick();
            if (j == 3) SYS_TIME_UPDATE = 1'b0;
            n_checks++;
            if ({IMP, BLANK, CMD_ERR, REQ_COMM, BUSY, IMP_CNT} !== {2'b00, j == 1, j <= 4, j <= 4, 16'd1})
                $display("FAIL abort t+%0d got imp/blank/err/req/busy=%b%b%b%b%b cnt=%0d want 00%b%b%b cnt=1",
                         j, IMP, BLANK, CMD_ERR, REQ_COMM, BUSY, IMP_CNT, j == 1, j <= 4, j <= 4);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int unsigned c = TIME[31:0] + 3;
        load(c, 2, 6, 12, 2, 2);
        for (int i = 0; i < 40; i++) begin
            e = exp_at(TIME[31:0], c);
            if (e.imp) break;
            tick();
        end
        n_checks++;
        if (IMP !== 1'b1) $display("FAIL rstmid_pulse got IMP=%b want 1", IMP);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({IMP, BLANK, BUSY, REQ_COMM} !== 4'b0000)
            $display("FAIL rstmid_async got imp/blank/busy/req=%b%b%b%b want 0000", IMP, BLANK, BUSY, REQ_COMM);
        else n_pass++;
        tick();
        tick();
        rst_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            tick();
            n_checks++;
            if ({obs(), CMD_ERR} !== '0)
                $display("FAIL rstmid_after[%0d] got busy=%b req=%b cnt=%0d want 0", j, BUSY, REQ_COMM, IMP_CNT);
            else n_pass++;
        end
    endtask

    initial begin
        CLK = 1'b0;
        rst_n = 1'b0;
        TIME = 64'd0;
        SYS_TIME_UPDATE = 1'b0;
        DATA_WR = 1'b0;
        TIME_START = 64'd0;
        N_impulse = 16'd0;
        TYPE_impulse = 2'd0;
        Interval_Ti = 32'd0;
        Interval_Tp = 32'd0;
        Tblank1 = 32'd0;
        Tblank2 = 32'd0;
        n_checks = 0;
        n_pass = 0;
        test_reset();
        test_nominal();
        test_reject();
        test_zero_blank();
        test_random();
        test_replace();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
